if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined OTTER core. Holds the PC register loaded from the PC mux
//  output, produces PC_4 back to the mux, drives the instruction-memory request/ack handshake and
//  fills the IF/ID pipeline register. Absorbs hazard-unit stalls with a 1-entry hold buffer and
//  EX-stage redirects (branch/JAL/JALR) with flush and in-flight discard.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC value loaded at reset
//  NOP_INSTR  32'h0000_0013  instruction placed in IF/ID when flushed or invalid (addi x0,x0,0)
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RST_N        in   1   asynchronous active-low reset
//  PC_NEXT      in   32  PC mux output; PC_4 on sequential advance, target on redirect
//  REDIRECT     in   1   EX resolved taken branch/jump this cycle; PC_NEXT holds target
//  STALL        in   1   hazard unit: IF/ID must not change this cycle
//  PC           out  32  current fetch PC
//  PC_4         out  32  PC + 4, to PC mux input 0
//  IMEM_REQ     out  1   fetch request; IMEM_ADDR stable while high until IMEM_ACK
//  IMEM_ADDR    out  32  fetch word address, bits [1:0] always 0
//  IMEM_ACK     in   1   1-cycle pulse: IMEM_RDATA valid, request complete
//  IMEM_RDATA   in   32  fetched instruction
//  IFID_PC      out  32  PC of instruction in IF/ID
//  IFID_INSTR   out  32  instruction in IF/ID
//  IFID_VALID   out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): PC=RESET_VEC, req_addr=RESET_VEC, state=S_START,
//   IMEM_REQ=0, IFID_PC=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0, hold_valid=0.
//  PC_4 = PC + 32'd4, combinational, wraps mod 2^32 (32'hFFFF_FFFC -> 0).
//  IMEM_ADDR = {req_addr[31:2],2'b00}; req_addr <= PC when a new request is issued.
//  States:
//   S_START  : IMEM_REQ=0; next cycle -> S_REQ (1 dead cycle after reset).
//   S_REQ    : IMEM_REQ=1. On ACK & !STALL: IF/ID<= {req_addr,RDATA,1}, PC<=PC_NEXT, stay S_REQ
//              (back-to-back fetch, issuing PC_NEXT). On ACK & STALL: hold<=RDATA, hold_valid=1,
//              -> S_HOLD. No ACK: stay, address unchanged.
//   S_HOLD   : IMEM_REQ=0, IF/ID frozen. When !STALL: IF/ID<=hold, PC<=PC_NEXT, hold_valid=0, -> S_REQ.
//   S_DISCARD: IMEM_REQ=1 at stale req_addr; on ACK drop RDATA, -> S_REQ with current PC.
//  Latency: 1-cycle-ACK memory gives 1 instr/cycle; instruction visible in IF/ID the cycle after ACK.
//  STALL freezes IF/ID and PC every cycle it is high; IFID_VALID not cleared by stall alone.
//  REDIRECT (priority over STALL and ACK): PC<=PC_NEXT, IFID_VALID<=0, IFID_INSTR<=NOP_INSTR,
//   hold_valid<=0. From S_REQ without ACK that cycle -> S_DISCARD; from S_REQ with ACK (data dropped),
//   S_HOLD, S_DISCARD with ACK -> S_REQ; S_DISCARD without ACK stays.
//  REDIRECT in S_START: PC<=PC_NEXT, still -> S_REQ.
//  PC_NEXT[1:0] ignored for IMEM_ADDR; PC itself stores all 32 bits (misalignment trapped elsewhere).
//  RST_N low mid-transaction: immediate return to reset values; outstanding IMEM request abandoned
//   (imem is reset by the same RST_N).
// STRUCTURE
//  otter_pkg: typedef enum logic [1:0] {S_START,S_REQ,S_HOLD,S_DISCARD} fetch_state_t;
//   localparams RESET_VEC_DEF, NOP_INSTR; typedef struct packed {pc,instr,valid} ifid_t.
//  One sub-module: fetch_hold_buf (1-entry instr buffer, load/drain/flush, valid flag).
//  Remainder: PC register, PC_4 adder, state machine, IF/ID register in this module.
// TESTING
//  1 Reset, ACK every cycle, PC_NEXT=PC_4 -> IMEM_ADDR 0,4,8,C; IFID_VALID=1 from cycle after first ACK.
//  2 ACK at addr 8 with STALL=1 for 3 cycles -> IMEM_REQ=0, IF/ID holds addr 4 instr;
//    STALL drop -> IFID_PC=8 next cycle, fetch resumes at C.
//  3 REDIRECT with PC_NEXT=32'h100 while request to 0x10 pending, ACK 2 cycles later -> 0x10 data
//    discarded, IFID_VALID=0, next IMEM_ADDR=0x100.
//  4 REDIRECT and STALL same cycle in S_HOLD -> hold dropped, IFID_INSTR=32'h13, IFID_VALID=0, PC=target.
//  5 PC=32'hFFFF_FFFC -> PC_4=0; sequential advance fetches addr 0.
//  6 RST_N low mid-S_HOLD -> all outputs reset values same cycle; S_START then S_REQ at RESET_VEC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared types and defaults for the OTTER instruction-fetch stage
package if_fetch_stage_pkg;
  typedef enum logic [1:0] {S_START, S_REQ, S_HOLD, S_DISCARD} fetch_state_t;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/ack handshake
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// if_fetch_stage_hold_buf: 1-entry buffer parking an instruction acked while IF/ID is stalled
module if_fetch_stage_hold_buf
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        flush_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o
);
  logic [31:0] data_q;
  logic        valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      if (load_i) data_q <= data_i;
      valid_q <= flush_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
    end
  end
  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, imem handshake and IF/ID register with stall hold and redirect discard
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_stage_if.master   imem,
  input  logic [31:0]        pc_next_i,
  input  logic               redirect_i,
  input  logic               stall_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_4_o,
  output logic [31:0]        ifid_pc_o,
  output logic [31:0]        ifid_instr_o,
  output logic               ifid_valid_o
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:2] req_addr_q, req_addr_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] hold_instr;
  logic        hold_valid, hold_load, hold_drain, ack;
  assign ack        = imem.ack;
  assign hold_load  = !redirect_i && state_q == S_REQ && ack && stall_i;
  assign hold_drain = !redirect_i && state_q == S_HOLD && !stall_i;
  if_fetch_stage_hold_buf #(.NOP_INSTR(NOP_INSTR)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .flush_i (redirect_i),
    .data_i  (imem.rdata),
    .data_o  (hold_instr),
    .valid_o (hold_valid)
  );
  // Redirect wins over stall and ack; an unacked request must still complete before refetching
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    if (redirect_i) begin
      pc_d    = pc_next_i;
      ifid_d  = '{pc: ifid_q.pc, instr: NOP_INSTR, valid: 1'b0};
      state_d = (state_q == S_REQ || state_q == S_DISCARD) && !ack ? S_DISCARD : S_REQ;
    end else begin
      case (state_q)
        S_START: state_d = S_REQ;
        S_REQ: begin
          if (ack && stall_i) state_d = S_HOLD;
          if (ack && !stall_i) begin
            ifid_d = '{pc: {req_addr_q, 2'b00}, instr: imem.rdata, valid: 1'b1};
            pc_d   = pc_next_i;
          end
        end
        S_HOLD: begin
          if (hold_drain) begin
            ifid_d  = '{pc: {req_addr_q, 2'b00}, instr: hold_instr, valid: hold_valid};
            pc_d    = pc_next_i;
            state_d = S_REQ;
          end
        end
        default: state_d = ack ? S_REQ : S_DISCARD;
      endcase
    end
    // Every fresh request fetches the PC being loaded this edge
    req_addr_d = (state_d == S_REQ && (state_q != S_REQ || ack)) ? pc_d[31:2] : req_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_START;
      pc_q       <= RESET_VEC;
      req_addr_q <= RESET_VEC[31:2];
      ifid_q     <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ifid_q     <= ifid_d;
    end
  end
  assign pc_o         = pc_q;
  assign pc_4_o       = pc_q + 32'd4;
  assign imem.req     = state_q == S_REQ || state_q == S_DISCARD;
  assign imem.addr    = {req_addr_q, 2'b00};
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_valid_o = ifid_q.valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed + randomized fetch traffic checked against a transaction-level model
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect, stall;
  logic [31:0] pc_next, pc, pc_4, ifid_pc, ifid_instr;
  logic        ifid_valid;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc, m_addr, m_held_instr, m_ifid_pc, m_ifid_instr;
  logic        m_req, m_startup, m_stale, m_held, m_ifid_valid;
  if_fetch_stage_if imem();
  if_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .pc_next_i    (pc_next),
    .redirect_i   (redirect),
    .stall_i      (stall),
    .pc_o         (pc),
    .pc_4_o       (pc_4),
    .ifid_pc_o    (ifid_pc),
    .ifid_instr_o (ifid_instr),
    .ifid_valid_o (ifid_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5EED_F00D;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_startup = 1'b1; m_stale = 1'b0;
    m_held = 1'b0; m_held_instr = 32'h0;
    m_ifid_pc = 32'h0; m_ifid_instr = 32'h13; m_ifid_valid = 1'b0;
  endtask
  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("pc_4", pc_4, m_pc + 32'd4);
    chk("imem_req", {31'b0, imem.req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem.addr, {m_addr[31:2], 2'b00});
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_ifid_valid});
    chk("ifid_instr", ifid_instr, m_ifid_instr);
    if (m_ifid_valid) chk("ifid_pc", ifid_pc, m_ifid_pc);
  endtask
  // One cycle: check, drive inputs, advance the model by the same event, wait for next negedge
  task automatic step(input logic a, input logic s, input logic r, input logic [31:0] t);
    logic [31:0] pcn, al;
    check_all();
    a   = a & m_req;
    pcn = r ? t : m_pc + 32'd4;
    imem.ack   = a;
    imem.rdata = a ? mem_word(imem.addr) : $urandom;
    stall      = s;
    redirect   = r;
    pc_next    = pcn;
    al = {m_addr[31:2], 2'b00};
    if (r) begin
      m_pc = pcn; m_ifid_valid = 1'b0; m_ifid_instr = 32'h13; m_held = 1'b0; m_startup = 1'b0;
      if (m_req && !a) m_stale = 1'b1;
      else begin m_req = 1'b1; m_addr = pcn; m_stale = 1'b0; end
    end else if (m_startup) begin
      m_startup = 1'b0; m_req = 1'b1; m_addr = m_pc;
    end else if (a && m_stale) begin
      m_stale = 1'b0; m_addr = m_pc;
    end else if (a && s) begin
      m_held = 1'b1; m_held_instr = mem_word(al); m_req = 1'b0;
    end else if (a) begin
      m_ifid_pc = al; m_ifid_instr = mem_word(al); m_ifid_valid = 1'b1;
      m_pc = pcn; m_addr = pcn;
    end else if (m_held && !s) begin
      m_ifid_pc = al; m_ifid_instr = m_held_instr; m_ifid_valid = 1'b1; m_held = 1'b0;
      m_pc = pcn; m_req = 1'b1; m_addr = pcn;
    end
    @(negedge clk);
  endtask
  task automatic random_run(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: t = $urandom & 32'hFFFF_FFFC;
        1: t = 32'hFFFF_FFFC;
        2: t = 32'h0000_0100;
        default: t = $urandom;
      endcase
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, t);
    end
  endtask
  initial begin
    imem.ack = 1'b0; imem.rdata = 32'h0; stall = 1'b0; redirect = 1'b0; pc_next = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h200);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    random_run(600);
    for (int i = 0; i < 50 && !m_held; i++) step(1, 1, 0, 0);
    if (!m_held) begin
      n_cmp++; n_err++;
      $display("FAIL hold_timeout: got no hold expected hold within 50 cycles");
    end
    chk("hold_req", {31'b0, imem.req}, 32'h0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_addr", imem.addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    random_run(400);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
